// File: rtl/frame_ones_pkg.sv
// frame_ones_pkg: shared FSM state type and popcount width helper for frame_ones_accumulator.
package frame_ones_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  function automatic int pc_width(input int dw);
    return $clog2(dw) + 1;
  endfunction
endpackage

// File: rtl/popcount_core.sv
// popcount_core: combinational count of the 1-bits in a DATA_WIDTH word.
module popcount_core
  import frame_ones_pkg::*;
#(
  parameter int DATA_WIDTH = 4
) (
  input  logic [DATA_WIDTH-1:0]               din,
  output logic [pc_width(DATA_WIDTH)-1:0]     cnt
);
  localparam int PW = pc_width(DATA_WIDTH);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < DATA_WIDTH; i++) cnt = cnt + PW'(din[i]);
  end
endmodule

// File: rtl/frame_ones_accumulator.sv
// frame_ones_accumulator: sums 1-bits over a din_last-terminated frame and holds the total until taken.
// Define FRAME_ONES_SATURATE_EN to clamp the total at its maximum on overflow instead of wrapping.
module frame_ones_accumulator
  import frame_ones_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int ACC_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  input  logic                  din_last,
  output logic                  din_ready,
  output logic [ACC_WIDTH-1:0]  dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  overflow
);
  localparam int PW = pc_width(DATA_WIDTH);
  state_t state, state_n;
  logic [PW-1:0] pc;
  logic [ACC_WIDTH-1:0] acc, pc_ext;
  logic [ACC_WIDTH:0] sum;
  logic ovf, accept;
  popcount_core #(.DATA_WIDTH(DATA_WIDTH)) u_pc (.din(din), .cnt(pc));
  assign pc_ext     = ACC_WIDTH'(pc);
  assign sum        = {1'b0, acc} + {1'b0, pc_ext};
  assign din_ready  = state != HOLD;
  assign dout_valid = state == HOLD;
  assign accept     = din_valid && din_ready;
  assign dout       = acc;
  assign overflow   = ovf;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (accept) state_n = din_last ? HOLD : ACCUM;
    else if (state == HOLD && dout_ready) state_n = IDLE;
  end
  // The carry out of the widened sum is the overflow indication.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      if (state == IDLE) begin
        acc <= pc_ext;
        ovf <= 1'b0;
      end else begin
        ovf <= ovf | sum[ACC_WIDTH];
`ifdef FRAME_ONES_SATURATE_EN
        acc <= (ovf || sum[ACC_WIDTH]) ? '1 : sum[ACC_WIDTH-1:0];
`else
        acc <= sum[ACC_WIDTH-1:0];
`endif
      end
    end
endmodule

// File: tb/tb_frame_ones_accumulator.sv
// tb_frame_ones_accumulator: directed frame table plus backpressure and reset sequences.
module tb_frame_ones_accumulator;
  logic clk = 0, resetn = 0;
  logic [3:0] din = '0;
  logic din_valid = 0, din_last = 0, dout_ready = 0;
  logic rdy0, dv0, ovf0, rdy1, dv1, ovf1;
  logic [15:0] dout0;
  logic [3:0] dout1;
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  frame_ones_accumulator #(.DATA_WIDTH(4), .ACC_WIDTH(16)) d0 (
    .clk(clk), .resetn(resetn), .din(din), .din_valid(din_valid), .din_last(din_last),
    .din_ready(rdy0), .dout(dout0), .dout_valid(dv0), .dout_ready(dout_ready), .overflow(ovf0));
  frame_ones_accumulator #(.DATA_WIDTH(4), .ACC_WIDTH(4)) d1 (
    .clk(clk), .resetn(resetn), .din(din), .din_valid(din_valid), .din_last(din_last),
    .din_ready(rdy1), .dout(dout1), .dout_valid(dv1), .dout_ready(dout_ready), .overflow(ovf1));

  typedef struct {
    string      name;
    int         n;
    logic [3:0] w [5];
    int         gap;
    int         exp0;
    int         exp1;
    logic       eovf1;
  } frame_t;

`ifdef FRAME_ONES_SATURATE_EN
  localparam int OVF_EXP1 = 15;
`else
  localparam int OVF_EXP1 = 4;
`endif

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] w, input logic last);
    int budget = 50;
    din = w;
    din_last = last;
    din_valid = 1;
    while (!rdy0 && budget > 0) begin
      tick();
      budget--;
    end
    chk("accept_wait", int'(rdy0), 1);
    tick();
    din_valid = 0;
    din_last = 0;
  endtask

  task automatic drain(input string name);
    dout_ready = 1;
    tick();
    dout_ready = 0;
    chk({name, "_dv_fall"}, int'(dv0), 0);
  endtask

  frame_t tbl [5];

  initial begin
    tbl[0] = '{"basic",  3, '{4'b1011, 4'b0001, 4'b1111, 4'b0, 4'b0}, 0, 8, 8, 1'b0};
    tbl[1] = '{"single0", 1, '{4'b0000, 4'b0, 4'b0, 4'b0, 4'b0}, 0, 0, 0, 1'b0};
    tbl[2] = '{"single3", 1, '{4'b0111, 4'b0, 4'b0, 4'b0, 4'b0}, 0, 3, 3, 1'b0};
    tbl[3] = '{"ovf",    5, '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111}, 0, 20, OVF_EXP1, 1'b1};
    tbl[4] = '{"gaps",   3, '{4'b1011, 4'b0001, 4'b1111, 4'b0, 4'b0}, 3, 8, 8, 1'b0};

    #12;
    chk("rst_dout", int'(dout0), 0);
    chk("rst_dv", int'(dv0), 0);
    chk("rst_ovf", int'(ovf0), 0);
    resetn = 1;
    tick();
    chk("rst_ready", int'(rdy0), 1);

    foreach (tbl[k]) begin
      for (int j = 0; j < tbl[k].n; j++) begin
        send(tbl[k].w[j], j == tbl[k].n - 1);
        if (j < tbl[k].n - 1)
          for (int g = 0; g < tbl[k].gap; g++) tick();
      end
      chk({tbl[k].name, "_dv"}, int'(dv0), 1);
      chk({tbl[k].name, "_dout"}, int'(dout0), tbl[k].exp0);
      chk({tbl[k].name, "_ovf"}, int'(ovf0), 0);
      chk({tbl[k].name, "_dout_w4"}, int'(dout1), tbl[k].exp1);
      chk({tbl[k].name, "_ovf_w4"}, int'(ovf1), int'(tbl[k].eovf1));
      drain(tbl[k].name);
    end

    send(4'b0101, 1);
    din = 4'b1111;
    din_last = 1;
    din_valid = 1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_ready", int'(rdy0), 0);
      chk("bp_dout", int'(dout0), 2);
      chk("bp_dv", int'(dv0), 1);
      tick();
    end
    dout_ready = 1;
    tick();
    dout_ready = 0;
    chk("bp_hs_dv", int'(dv0), 0);
    chk("bp_hs_dout", int'(dout0), 2);
    tick();
    din_valid = 0;
    din_last = 0;
    chk("bp_next_dv", int'(dv0), 1);
    chk("bp_next_dout", int'(dout0), 4);
    drain("bp");

    send(4'b1111, 0);
    send(4'b1111, 0);
    chk("mid_acc", int'(dout0), 8);
    resetn = 0;
    #1;
    chk("mid_rst_dout", int'(dout0), 0);
    chk("mid_rst_dv", int'(dv0), 0);
    resetn = 1;
    tick();
    send(4'b0011, 1);
    chk("mid_dv", int'(dv0), 1);
    chk("mid_dout", int'(dout0), 2);
    chk("mid_ovf", int'(ovf0), 0);
    drain("mid");

    send(4'b1111, 1);
    chk("hold_dv", int'(dv0), 1);
    resetn = 0;
    #1;
    chk("hold_rst_dv", int'(dv0), 0);
    chk("hold_rst_dout", int'(dout0), 0);
    chk("hold_rst_ready", int'(rdy0), 1);
    resetn = 1;
    tick();
    send(4'b0001, 1);
    chk("hold_new_dout", int'(dout0), 1);
    drain("hold");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
